// File: rtl/s15_rdata_skid_pkg.sv
// Shared types for the slave-15 read-data return stage.
// The state enum is the pair {skid_valid, main_valid}, so each bit doubles as a valid flag.
package s15_rdata_skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } skid_state_e;

endpackage

// File: rtl/s15_rdata_skid_sat_counter.sv
// Saturating event counter with a sticky "reached all-ones" flag.
// Intended for reuse by other bus monitor blocks.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 sat
);

    localparam logic [CNT_WIDTH-1:0] CountMax = '1;

    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 sat_q, sat_d;

    // Once the count is all-ones it stops; the flag latches on the same edge it gets there.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != CountMax)) begin
            count_d = count_q + 1'b1;
        end
        sat_d = sat_q | (count_d == CountMax);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count = count_q;
    assign sat   = sat_q;

endmodule

// File: rtl/s15_rdata_skid.sv
// Registered 2-entry skid buffer between the slave-15 read-data mux and master 0.
// in_ready and out_valid come straight from state flops, so neither path is combinational.
module s15_rdata_skid
    import s15_rdata_skid_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  xfer_count,
    output logic                  xfer_sat
);

    skid_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] mainData_q, mainData_d;
    logic [DATA_WIDTH-1:0] skidData_q, skidData_d;
    logic                  inHs, outHs;
    logic                  loadMainFromIn, loadMainFromSkid, loadSkid;

    assign in_ready  = ~state_q[1];
    assign out_valid = state_q[0];
    assign out_data  = mainData_q;

    assign inHs  = in_valid & in_ready;
    assign outHs = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (inHs) state_d = ONE;
            ONE: begin
                if (inHs && !outHs) begin
                    state_d = FULL;
                end else if (!inHs && outHs) begin
                    state_d = EMPTY;
                end
            end
            FULL:    if (outHs) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // Data-path steering: main refills from the input when it is (or is becoming) free,
    // otherwise the incoming word parks in skid until main drains.
    always_comb begin
        loadMainFromIn   = 1'b0;
        loadMainFromSkid = 1'b0;
        loadSkid         = 1'b0;
        case (state_q)
            EMPTY: loadMainFromIn = inHs;
            ONE: begin
                loadMainFromIn = inHs & outHs;
                loadSkid       = inHs & ~outHs;
            end
            FULL:  loadMainFromSkid = outHs;
            default: ;
        endcase
    end

    always_comb begin
        mainData_d = mainData_q;
        if (loadMainFromIn) begin
            mainData_d = in_data;
        end else if (loadMainFromSkid) begin
            mainData_d = skidData_q;
        end
        skidData_d = loadSkid ? in_data : skidData_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mainData_q <= '0;
            skidData_q <= '0;
        end else begin
            mainData_q <= mainData_d;
            skidData_q <= skidData_d;
        end
    end

    sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_xfer_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (outHs),
        .count(xfer_count),
        .sat  (xfer_sat)
    );

endmodule
